uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Parametrised UART transmitter. Successor to the fixed 8N1 transmitter.
- Configurable data width, parity mode, stop-bit count and bit period.
- Small input FIFO so an AXI-stream producer can queue several words. Frames go out back-to-back with no idle gap.
- Sits between a byte/word stream source and the serial pin.

Parameters:
- CYCLES_PER_BIT, 434: clk cycles per serial bit, >= 2.
- DATA_BITS, 8: payload bits per frame, 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries, power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tx  out  1  serial output, idle high
- tready  out  1  AXI-stream ready: FIFO not full
- tvalid  in  1  AXI-stream valid
- tdata  in  DATA_BITS  word to send, LSB transmitted first
- busy  out  1  high while a frame is on the line or the FIFO is non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values, asserted asynchronously:
  - tx = 1, tready = 0, busy = 0, fifo_level = 0.
  - FSM goes to IDLE; FIFO and counters are cleared.
  - First clk edge after deassertion: tready = 1.
- Handshake:
  - A word is accepted on a rising edge with tvalid && tready.
  - tready = (fifo_level != FIFO_DEPTH) and is driven from registered state only.
  - tdata is never sampled without tready.
  - Push and pop in the same cycle leaves the level unchanged.
- Frame order: start (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
  - Even parity: parity bit = XOR of the data bits.
  - Odd parity: parity bit = inverted XOR.
  - Each bit is held on tx for exactly CYCLES_PER_BIT cycles.
  - tx is registered.
- FSM states and transitions:
  - IDLE: tx = 1. When FIFO is non-empty, pop the head, load the shift register, go to START.
  - START -> DATA.
  - DATA: shift once per bit period. After DATA_BITS bits, go to PARITY if PARITY != 0, otherwise STOP.
  - PARITY -> STOP.
  - STOP: hold for STOP_BITS periods.
    - At the end of the last period, if the FIFO is non-empty, pop and go directly to START (zero idle cycles).
    - Otherwise go to IDLE.
- Latency: a word pushed into an empty FIFO on edge N with FSM in IDLE drives tx low starting edge N+2.
- Counters:
  - Cycle counter width $clog2(CYCLES_PER_BIT); wraps to 0 at CYCLES_PER_BIT-1.
  - Bit counter width $clog2(DATA_BITS+1).
  - No counter overflows for legal parameters.
- busy = (state != IDLE) || (fifo_level != 0).
- Illegal parameters (DATA_BITS out of range, PARITY > 2, STOP_BITS not 1 or 2, FIFO_DEPTH not a power of 2) are rejected with an elaboration-time $error.
- Reset mid-frame: tx returns to 1 immediately, queued words are discarded, no partial frame resumes.

Optional Feature:
- Macro: UART_TX_FRAME_BREAK_EN.
- Defined:
  - Adds input port break_req (1 bit) and state BREAK.
  - In IDLE, or at the end of STOP, break_req = 1 takes priority over a FIFO pop and enters BREAK.
  - BREAK: tx = 0. Stays until break_req = 0 and at least (1+DATA_BITS+parity+STOP_BITS) bit periods have elapsed.
  - Then emits one stop-bit period of 1 and returns to IDLE.
  - The FIFO keeps accepting words during BREAK.
- Not defined: no break_req port, no BREAK state, behaviour exactly as above.

Test Plan:
- CYCLES_PER_BIT=4, 8N1; push 0x55 after reset -> tx low at edge N+2; line 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit; 40 cycles total; busy drops the cycle after the stop bit ends.
- PARITY=1, DATA_BITS=7; send 0x07 -> parity bit 1. PARITY=2; send 0x07 -> parity bit 0. STOP_BITS=2 -> 8 high cycles before the next start.
- FIFO_DEPTH=4; hold tvalid high with 0x01..0x06 while the FSM is busy -> tready low once fifo_level = 4; words stream with no idle gap between stop and start; serial order is 0x01..0x06.
- Assert rst_n low mid data bit 3 of 0xA3 with 2 words queued -> tx = 1 immediately; fifo_level = 0; after release tx stays high with no residual frame.
- DATA_BITS=9; send 0x1FF then 0x000 -> 9 ones and 9 zeros respectively, framed correctly; the push of the second word coincides with the pop of the first and fifo_level is unchanged.
- With UART_TX_FRAME_BREAK_EN: break_req high for 2 cycles in IDLE (8N1, CYCLES_PER_BIT=4) -> tx low for 40 cycles, then 4 cycles high, then the queued word is sent.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a small input FIFO.
// Latency: a word pushed into an empty FIFO while the FSM is idle drives tx low two clk edges later.
// Backpressure: tready is registered and drops while the FIFO is full; frames stream back-to-back.
// Optional feature: define UART_TX_FRAME_BREAK_EN to add the break_req input and a BREAK state.

// uart_tx_frame_fifo: word FIFO with registered write-ready and occupancy.
// Latency: a word written on edge N is visible on rd_dat/rd_vld after edge N.
// Backpressure: wr_rdy is registered and low while full; simultaneous push and pop keep the level.
module uart_tx_frame_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_vld,
  output logic                   wr_rdy,
  input  logic [WIDTH-1:0]       wr_dat,
  input  logic                   rd_en,
  output logic                   rd_vld,
  output logic [WIDTH-1:0]       rd_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic             push;
  logic             pop;

  assign push   = wr_vld && wr_rdy;
  assign rd_vld = (level != '0);
  assign pop    = rd_en && rd_vld;
  assign rd_dat = mem[rd_ptr];

  // Next occupancy: a push and a pop in the same cycle cancel out.
  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + 1'b1;
    end else if (!push && pop) begin
      level_nxt = level - 1'b1;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers, occupancy and the registered ready (low out of reset, high one edge later).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      wr_rdy <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level  <= level_nxt;
      wr_rdy <= (level_nxt != FULL);
    end
  end
endmodule

module uart_tx_frame #(
  parameter int CYCLES_PER_BIT = 434,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        tx,
  output logic                        tready,
  input  logic                        tvalid,
  input  logic [DATA_BITS-1:0]        tdata,
`ifdef UART_TX_FRAME_BREAK_EN
  input  logic                        break_req,
`endif
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  // Reject illegal configurations at elaboration.
  if (CYCLES_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CYCLES_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_frame: FIFO_DEPTH must be a power of 2, >= 2");
  end

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_EN    = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 2);

`ifdef UART_TX_FRAME_BREAK_EN
  // A break lasts at least one full frame time.
  localparam int BRK_BITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int KW       = $clog2(BRK_BITS + 1);
  localparam logic [KW-1:0] BRK_LAST = KW'(BRK_BITS);
  localparam logic [KW-1:0] BRK_PEN  = KW'(BRK_BITS - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_FRAME_BREAK_EN
    , S_BREAK
`endif
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cyc_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   fifo_rd_vld;
  logic [DATA_BITS-1:0]   fifo_rd_dat;
  logic                   pop;
  logic                   bit_end;
  logic                   frame_end;
  logic                   slot_free;
  logic                   take_break;
  logic                   line_bit;
`ifdef UART_TX_FRAME_BREAK_EN
  logic [KW-1:0]          brk_cnt;
  logic                   brk_tail;
  logic                   brk_done;
`endif

  uart_tx_frame_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (tvalid),
    .wr_rdy (tready),
    .wr_dat (tdata),
    .rd_en  (pop),
    .rd_vld (fifo_rd_vld),
    .rd_dat (fifo_rd_dat),
    .level  (fifo_level)
  );

  assign busy = (state != S_IDLE) || (fifo_level != '0);

  // Decide when the line can take a new frame (or a break) and whether the FIFO head is popped.
  always_comb begin
    bit_end    = (cyc_cnt == CYC_LAST);
    frame_end  = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
    slot_free  = (state == S_IDLE) || frame_end;
    take_break = 1'b0;
`ifdef UART_TX_FRAME_BREAK_EN
    // The final break period counts as elapsed on the edge that ends it.
    brk_done   = (brk_cnt == BRK_LAST) || (bit_end && (brk_cnt == BRK_PEN));
    // The trailing mark after a break hands over to the next frame with no idle cycle.
    slot_free  = slot_free || ((state == S_BREAK) && brk_tail && bit_end);
    take_break = slot_free && break_req;
`endif
    pop = slot_free && fifo_rd_vld && !take_break;
  end

  // Line level implied by the current state; registered into tx one cycle later.
  always_comb begin
    line_bit = 1'b1;
    case (state)
      S_START:  line_bit = 1'b0;
      S_DATA:   line_bit = shreg[0];
      S_PARITY: line_bit = par_bit;
`ifdef UART_TX_FRAME_BREAK_EN
      S_BREAK:  line_bit = brk_tail;
`endif
      default:  line_bit = 1'b1;
    endcase
  end

  // Frame sequencer: bit timing, shift register, parity and the registered tx output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
`ifdef UART_TX_FRAME_BREAK_EN
      brk_cnt  <= '0;
      brk_tail <= 1'b0;
`endif
    end else begin
      tx      <= line_bit;
      cyc_cnt <= (state == S_IDLE || bit_end) ? '0 : cyc_cnt + 1'b1;
      if (take_break) begin
`ifdef UART_TX_FRAME_BREAK_EN
        state    <= S_BREAK;
        cyc_cnt  <= '0;
        brk_cnt  <= '0;
        brk_tail <= 1'b0;
`endif
      end else if (pop) begin
        state   <= S_START;
        shreg   <= fifo_rd_dat;
        par_bit <= (^fifo_rd_dat) ^ PAR_ODD;
        bit_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
          end
          S_START: begin
            if (bit_end) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            if (bit_end) begin
              shreg <= shreg >> 1;
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                state   <= PAR_EN ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          S_PARITY: begin
            if (bit_end) begin
              state   <= S_STOP;
              bit_cnt <= '0;
            end
          end
          S_STOP: begin
            if (bit_end) begin
              if (bit_cnt == STOP_LAST) begin
                state <= S_IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
`ifdef UART_TX_FRAME_BREAK_EN
          S_BREAK: begin
            if (!brk_tail) begin
              if (bit_end && brk_cnt != BRK_LAST) begin
                brk_cnt <= brk_cnt + 1'b1;
              end
              // Release may come mid-period; the trailing mark then starts a fresh bit period.
              if (!break_req && brk_done) begin
                brk_tail <= 1'b1;
                cyc_cnt  <= '0;
              end
            end else if (bit_end) begin
              state    <= S_IDLE;
              brk_tail <= 1'b0;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1, 7E2, 9O1) at 4 clk per bit.
// Expected serial waveforms come from a frame model fed by a scoreboard queue of pushed words.
// Outputs are sampled on the falling clock edge; inputs are driven on the falling edge.
module tb_uart_tx_frame;
  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       tx_a, tready_a, tvalid_a, busy_a;
  logic [7:0] tdata_a;
  logic [2:0] level_a;
  logic       tx_b, tready_b, tvalid_b, busy_b;
  logic [6:0] tdata_b;
  logic [2:0] level_b;
  logic       tx_c, tready_c, tvalid_c, busy_c;
  logic [8:0] tdata_c;
  logic [2:0] level_c;
  logic       break_req_a;
  logic       mon_tx;
  int         mon_sel;
  int         n_checks;
  int         n_pass;
  logic [8:0] sb_q [$];

  uart_tx_frame #(.CYCLES_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .tx(tx_a), .tready(tready_a), .tvalid(tvalid_a), .tdata(tdata_a),
`ifdef UART_TX_FRAME_BREAK_EN
    .break_req(break_req_a),
`endif
    .busy(busy_a), .fifo_level(level_a));

  uart_tx_frame #(.CYCLES_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .tx(tx_b), .tready(tready_b), .tvalid(tvalid_b), .tdata(tdata_b),
`ifdef UART_TX_FRAME_BREAK_EN
    .break_req(1'b0),
`endif
    .busy(busy_b), .fifo_level(level_b));

  uart_tx_frame #(.CYCLES_PER_BIT(CPB), .DATA_BITS(9), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .tx(tx_c), .tready(tready_c), .tvalid(tvalid_c), .tdata(tdata_c),
`ifdef UART_TX_FRAME_BREAK_EN
    .break_req(1'b0),
`endif
    .busy(busy_c), .fifo_level(level_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (mon_sel)
      1:       mon_tx = tx_b;
      2:       mon_tx = tx_c;
      default: mon_tx = tx_a;
    endcase
  end

  // Expected line, one entry per clk cycle, for one frame of word w.
  function automatic logic [63:0] frame_exp(input logic [8:0] w, input int db, input int par, input int sb);
    logic [15:0] bits;
    logic [63:0] r;
    logic        p;
    int          n;
    bits = '1;
    p    = 1'b0;
    n    = 0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < db; i++) begin
      bits[n] = w[i];
      p ^= w[i];
      n++;
    end
    if (par != 0) begin
      bits[n] = (par == 2) ? ~p : p;
      n++;
    end
    n += sb;
    r = '0;
    for (int i = 0; i < n * CPB; i++) r[i] = bits[i / CPB];
    return r;
  endfunction

  function automatic int frame_len(input int db, input int par, input int sb);
    return (1 + db + ((par != 0) ? 1 : 0) + sb) * CPB;
  endfunction

  function automatic logic [63:0] frame_got(input logic [511:0] line, input int f, input int len);
    logic [511:0] sh;
    logic [63:0]  mask;
    sh   = line >> (f * len);
    mask = (64'd1 << len) - 64'd1;
    return sh[63:0] & mask;
  endfunction

  // Waits (bounded) for the selected line to go low, then records ncyc samples from that point.
  task automatic capture(input int ncyc, output logic [511:0] line, output int waited);
    line   = '0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (mon_tx !== 1'b0 && waited < 2000);
    if (mon_tx !== 1'b0) begin
      waited = -1;
      return;
    end
    line[0] = mon_tx;
    for (int i = 1; i < ncyc; i++) begin
      @(negedge clk);
      line[i] = mon_tx;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({tx_a, tx_b, tx_c} !== 3'b111) $display("FAIL reset_tx: got %b expected 111", {tx_a, tx_b, tx_c});
    else n_pass++;
    n_checks++;
    if ({tready_a, tready_b, tready_c} !== 3'b000) $display("FAIL reset_tready: got %b expected 000", {tready_a, tready_b, tready_c});
    else n_pass++;
    n_checks++;
    if ({busy_a, busy_b, busy_c} !== 3'b000) $display("FAIL reset_busy: got %b expected 000", {busy_a, busy_b, busy_c});
    else n_pass++;
    n_checks++;
    if ({level_a, level_b, level_c} !== 9'd0) $display("FAIL reset_level: got %h expected 0", {level_a, level_b, level_c});
    else n_pass++;
    rst_n = 1'b1;
    n_checks++;
    if (tready_a !== 1'b0) $display("FAIL release_tready_before_edge: got %b expected 0", tready_a);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({tready_a, tready_b, tready_c} !== 3'b111) $display("FAIL release_tready_after_edge: got %b expected 111", {tready_a, tready_b, tready_c});
    else n_pass++;
  endtask

  task automatic test_8n1();
    logic [511:0] line;
    logic [8:0]   w;
    int           waited;
    mon_sel = 0;
    @(negedge clk);
    tvalid_a = 1'b1;
    tdata_a  = 8'h55;
    sb_q.push_back(9'h055);
    @(posedge clk);
    @(negedge clk);
    tvalid_a = 1'b0;
    n_checks++;
    if (level_a !== 3'd1 || busy_a !== 1'b1) $display("FAIL 8n1_after_push: level=%0d busy=%b expected level=1 busy=1", level_a, busy_a);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (tx_a !== 1'b1 || level_a !== 3'd0) $display("FAIL 8n1_after_pop: tx=%b level=%0d expected tx=1 level=0", tx_a, level_a);
    else n_pass++;
    capture(40, line, waited);
    n_checks++;
    if (waited !== 1) $display("FAIL 8n1_latency: start after %0d cycles expected 1", waited);
    else n_pass++;
    w = sb_q.pop_front();
    n_checks++;
    if (frame_got(line, 0, 40) !== frame_exp(w, 8, 0, 1))
      $display("FAIL 8n1_frame: got %h expected %h", frame_got(line, 0, 40), frame_exp(w, 8, 0, 1));
    else n_pass++;
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL 8n1_busy_end: got %b expected 0", busy_a);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [511:0] line;
    logic [8:0]   w;
    int           waited;
    int           sent;
    int           cyc;
    int           tr_bad;
    bit           saw_full;
    logic         hs;
    mon_sel  = 0;
    sent     = 0;
    cyc      = 0;
    tr_bad   = 0;
    saw_full = 1'b0;
    fork
      begin
        while (sent < 6 && cyc < 1000) begin
          @(negedge clk);
          tvalid_a = 1'b1;
          tdata_a  = 8'(sent + 1);
          if (level_a == 3'd4) saw_full = 1'b1;
          if (tready_a !== (level_a != 3'd4)) tr_bad++;
          hs = tready_a;
          @(posedge clk);
          if (hs) begin
            sb_q.push_back(9'(sent + 1));
            sent++;
          end
          cyc++;
        end
        @(negedge clk);
        tvalid_a = 1'b0;
      end
      begin
        capture(6 * 40, line, waited);
      end
    join
    n_checks++;
    if (tr_bad !== 0) $display("FAIL b2b_tready: %0d cycles with tready != (level != 4), expected 0", tr_bad);
    else n_pass++;
    n_checks++;
    if (saw_full !== 1'b1) $display("FAIL b2b_full: fifo_level 4 seen=%b expected 1", saw_full);
    else n_pass++;
    n_checks++;
    if (sent !== 6 || waited < 0) $display("FAIL b2b_accept: accepted %0d words, start wait %0d, expected 6 and a start", sent, waited);
    else n_pass++;
    for (int f = 0; f < 6; f++) begin
      w = (sb_q.size() != 0) ? sb_q.pop_front() : 9'h1FF;
      n_checks++;
      if (frame_got(line, f, 40) !== frame_exp(w, 8, 0, 1))
        $display("FAIL b2b_frame%0d: got %h expected %h", f, frame_got(line, f, 40), frame_exp(w, 8, 0, 1));
      else n_pass++;
    end
  endtask

  task automatic test_parity_stop2();
    logic [511:0] line;
    logic [8:0]   w;
    int           waited;
    mon_sel = 1;
    @(negedge clk);
    tvalid_b = 1'b1;
    tdata_b  = 7'h07;
    sb_q.push_back(9'h007);
    @(posedge clk);
    @(negedge clk);
    tdata_b = 7'h05;
    sb_q.push_back(9'h005);
    @(posedge clk);
    @(negedge clk);
    tvalid_b = 1'b0;
    n_checks++;
    if (level_b !== 3'd1) $display("FAIL par_level: got %0d expected 1", level_b);
    else n_pass++;
    capture(2 * 44, line, waited);
    n_checks++;
    if (waited !== 1) $display("FAIL par_latency: start after %0d cycles expected 1", waited);
    else n_pass++;
    for (int f = 0; f < 2; f++) begin
      w = sb_q.pop_front();
      n_checks++;
      if (frame_got(line, f, 44) !== frame_exp(w, 7, 1, 2))
        $display("FAIL par_even_frame%0d: got %h expected %h", f, frame_got(line, f, 44), frame_exp(w, 7, 1, 2));
      else n_pass++;
    end
  endtask

  task automatic test_9bit();
    logic [511:0] line;
    logic [8:0]   w;
    int           waited;
    mon_sel = 2;
    @(negedge clk);
    tvalid_c = 1'b1;
    tdata_c  = 9'h1FF;
    sb_q.push_back(9'h1FF);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (level_c !== 3'd1) $display("FAIL 9bit_level_push: got %0d expected 1", level_c);
    else n_pass++;
    tdata_c = 9'h000;
    sb_q.push_back(9'h000);
    @(posedge clk);
    @(negedge clk);
    tvalid_c = 1'b0;
    n_checks++;
    if (level_c !== 3'd1) $display("FAIL 9bit_level_push_pop: got %0d expected 1", level_c);
    else n_pass++;
    capture(2 * 48, line, waited);
    n_checks++;
    if (waited !== 1) $display("FAIL 9bit_latency: start after %0d cycles expected 1", waited);
    else n_pass++;
    for (int f = 0; f < 2; f++) begin
      w = sb_q.pop_front();
      n_checks++;
      if (frame_got(line, f, 48) !== frame_exp(w, 9, 2, 1))
        $display("FAIL 9bit_odd_frame%0d: got %h expected %h", f, frame_got(line, f, 48), frame_exp(w, 9, 2, 1));
      else n_pass++;
    end
  endtask

`ifdef UART_TX_FRAME_BREAK_EN
  task automatic test_break();
    logic [511:0] line;
    logic [8:0]   w;
    logic [2:0]   lvl;
    int           waited;
    int           errs;
    mon_sel = 0;
    errs    = 0;
    lvl     = '0;
    @(negedge clk);
    tvalid_a = 1'b1;
    tdata_a  = 8'h3C;
    sb_q.push_back(9'h03C);
    @(posedge clk);
    @(negedge clk);
    tvalid_a    = 1'b0;
    break_req_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    break_req_a = 1'b0;
    for (int i = 0; i < 44; i++) begin
      if (i != 0) @(negedge clk);
      if (tx_a !== ((i < 40) ? 1'b0 : 1'b1)) errs++;
      if (i == 39) lvl = level_a;
    end
    n_checks++;
    if (errs !== 0) $display("FAIL break_line: %0d wrong samples, expected 40 low then 4 high", errs);
    else n_pass++;
    n_checks++;
    if (lvl !== 3'd1) $display("FAIL break_fifo_hold: level %0d expected 1", lvl);
    else n_pass++;
    capture(40, line, waited);
    n_checks++;
    if (waited !== 1) $display("FAIL break_next_start: start after %0d cycles expected 1", waited);
    else n_pass++;
    w = sb_q.pop_front();
    n_checks++;
    if (frame_got(line, 0, 40) !== frame_exp(w, 8, 0, 1))
      $display("FAIL break_frame: got %h expected %h", frame_got(line, 0, 40), frame_exp(w, 8, 0, 1));
    else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] words [3];
    int         guard;
    int         errs;
    words[0] = 8'hA3;
    words[1] = 8'h11;
    words[2] = 8'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tvalid_a = 1'b1;
      tdata_a  = words[i];
      guard    = 0;
      while (tready_a !== 1'b1 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk);
    end
    @(negedge clk);
    tvalid_a = 1'b0;
    guard    = 0;
    while (tx_a !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (17) @(negedge clk);
    n_checks++;
    if (tx_a !== 1'b0 || level_a !== 3'd2) $display("FAIL midrst_before: tx=%b level=%0d expected tx=0 level=2", tx_a, level_a);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_a !== 1'b1) $display("FAIL midrst_tx: got %b expected 1", tx_a);
    else n_pass++;
    n_checks++;
    if (level_a !== 3'd0 || busy_a !== 1'b0 || tready_a !== 1'b0)
      $display("FAIL midrst_state: level=%0d busy=%b tready=%b expected 0 0 0", level_a, busy_a, tready_a);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    errs  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd0) errs++;
    end
    n_checks++;
    if (errs !== 0) $display("FAIL midrst_residual: %0d cycles with activity after release, expected 0", errs);
    else n_pass++;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    mon_sel     = 0;
    rst_n       = 1'b0;
    tvalid_a    = 1'b0;
    tvalid_b    = 1'b0;
    tvalid_c    = 1'b0;
    tdata_a     = '0;
    tdata_b     = '0;
    tdata_c     = '0;
    break_req_a = 1'b0;
    test_reset();
    test_8n1();
    test_back_to_back();
    test_parity_stop2();
    test_9bit();
`ifdef UART_TX_FRAME_BREAK_EN
    test_break();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
